// File: rtl/ccff_chain_loader_pkg.sv
// Shared state encodings and word-geometry helpers for the configuration-chain loader.
// Geometry helpers are functions so each loader instance can size itself from its own parameters.
package ccff_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Wide enough to hold a per-word bit limit up to 32.
  localparam int LIM_W = 6;

  localparam int DEF_CHAIN_LEN = 8;
  localparam int DEF_WORD_W    = 8;

  function automatic int last_bits(input int chain_len, input int word_w);
    return chain_len % word_w;
  endfunction

  function automatic int n_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int word_limit(input int chain_len, input int word_w, input logic is_last);
    if (is_last && (last_bits(chain_len, word_w) != 0))
      return last_bits(chain_len, word_w);
    return word_w;
  endfunction

  localparam int LAST_BITS = last_bits(DEF_CHAIN_LEN, DEF_WORD_W);
  localparam int N_WORDS   = n_words(DEF_CHAIN_LEN, DEF_WORD_W);

endpackage

// File: rtl/ccff_chain_loader_serializer.sv
// Per-word datapath: LSB-first shift register toward the chain head and readback capture from the tail.
// rb_word already includes the tail bit sampled this cycle, so the top can latch it on the final shift.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic              tail,
  input  logic [LIM_W-1:0]  limit,
  output logic              head,
  output logic              word_end,
  output logic [WORD_W-1:0] rb_word
);

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rbuf;
  logic [LIM_W-1:0]  idx;

  assign head     = sreg[0];
  assign word_end = ((idx + LIM_W'(1)) == limit);

  always_comb begin
    rb_word = rbuf;
    for (int i = 0; i < WORD_W; i++) begin
      if (idx == LIM_W'(i)) rb_word[i] = tail;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sreg <= '0;
      rbuf <= '0;
      idx  <= '0;
    end else if (load) begin
      // Clearing rbuf keeps unshifted bits of a partial last word at zero.
      sreg <= data;
      rbuf <= '0;
      idx  <= '0;
    end else if (shift) begin
      sreg <= sreg >> 1;
      rbuf <= rb_word;
      idx  <= idx + LIM_W'(1);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Programs one configuration-chain segment from host words and returns the displaced contents as readback.
// FSM IDLE->FETCH->SHIFT(->FETCH...)->DONE; abort wins over handshake and completion.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 12
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int WORDS_PER_LOAD = n_words(CHAIN_LEN, WORD_W);

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic              load;
  logic              shift;
  logic              word_end;
  logic              last_bit;
  logic              sreg_head;
  logic [LIM_W-1:0]  limit;
  logic [WORD_W-1:0] rb_word;

  assign cfg_ready     = (state == ST_FETCH);
  assign ccff_shift_en = (state == ST_SHIFT);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign ccff_head     = ccff_shift_en & sreg_head;

  assign load     = cfg_ready & cfg_valid & ~abort;
  assign shift    = ccff_shift_en & ~abort;
  assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign limit    = LIM_W'(word_limit(CHAIN_LEN, WORD_W, word_cnt == CNT_W'(WORDS_PER_LOAD - 1)));

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .load       (load),
    .shift      (shift),
    .data       (cfg_data),
    .tail       (ccff_tail),
    .limit      (limit),
    .head       (sreg_head),
    .word_end   (word_end),
    .rb_word    (rb_word)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) state <= ST_IDLE;
          else if (cfg_valid) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit || word_end) begin
              rb_data  <= rb_word;
              rb_valid <= 1'b1;
              word_cnt <= word_cnt + CNT_W'(1);
              state    <= last_bit ? ST_DONE : ST_FETCH;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Two loaders (8-bit chain, 20-bit chain) each driving a behavioural chain model; table-driven loads
// plus hand sequences for stall, abort, reset and spurious start; readback checked via scoreboard.
module tb_ccff_chain_loader;

  typedef struct {
    int                d;
    logic [19:0]       pre;
    logic [2:0][7:0]   w;
    int                stall;
    bit                noise;
    logic [19:0]       exp_chain;
    logic [2:0][7:0]   exp_rb;
  } vec_t;

  logic       clk;
  logic       prog_reset;
  logic       start_s[2];
  logic       abort_s[2];
  logic [7:0] cfg_data_s[2];
  logic       cfg_valid_s[2];
  logic       cfg_ready_s[2];
  logic       head_s[2];
  logic       shen_s[2];
  logic       tail_s[2];
  logic [7:0] rb_data_s[2];
  logic       rbv_s[2];
  logic       busy_s[2];
  logic       done_s[2];

  logic [19:0] chain[2];
  logic        pre_en[2];
  logic [19:0] pre_val[2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int shift_cnt[2];
  int done_cnt[2];
  int rb_cnt[2];
  logic prev_shen[2];
  int n_chk;
  int n_fail;
  vec_t vecs[5];

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(12)) dut0 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[0]), .abort(abort_s[0]),
    .cfg_data(cfg_data_s[0]), .cfg_valid(cfg_valid_s[0]), .cfg_ready(cfg_ready_s[0]),
    .ccff_head(head_s[0]), .ccff_shift_en(shen_s[0]), .ccff_tail(tail_s[0]),
    .rb_data(rb_data_s[0]), .rb_valid(rbv_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(12)) dut1 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[1]), .abort(abort_s[1]),
    .cfg_data(cfg_data_s[1]), .cfg_valid(cfg_valid_s[1]), .cfg_ready(cfg_ready_s[1]),
    .ccff_head(head_s[1]), .ccff_shift_en(shen_s[1]), .ccff_tail(tail_s[1]),
    .rb_data(rb_data_s[1]), .rb_valid(rbv_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  always #5 clk = ~clk;

  // Chain models: head enters the top flop, tail is flop 0.
  always @(posedge clk) begin
    if (pre_en[0]) chain[0] <= pre_val[0];
    else if (shen_s[0]) chain[0] <= {12'd0, head_s[0], chain[0][7:1]};
    if (pre_en[1]) chain[1] <= pre_val[1];
    else if (shen_s[1]) chain[1] <= {head_s[1], chain[1][19:1]};
  end
  assign tail_s[0] = chain[0][0];
  assign tail_s[1] = chain[1][0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (shen_s[d]) shift_cnt[d]++;
      if (done_s[d]) begin
        done_cnt[d]++;
        check("done_with_last_rb", 32'(rbv_s[d]), 32'd1);
      end
      if (rbv_s[d]) begin
        rb_cnt[d]++;
        check("rb_after_shift", 32'(prev_shen[d]), 32'd1);
        if (d == 0) begin
          if (exp_q0.size() == 0) check("rb_unexpected0", 32'd1, 32'd0);
          else check("rb_data0", 32'(rb_data_s[0]), 32'(exp_q0.pop_front()));
        end else begin
          if (exp_q1.size() == 0) check("rb_unexpected1", 32'd1, 32'd0);
          else check("rb_data1", 32'(rb_data_s[1]), 32'(exp_q1.pop_front()));
        end
      end
      prev_shen[d] = shen_s[d];
    end
  end

  task automatic preload(input int d, input logic [19:0] val);
    pre_val[d] = val;
    pre_en[d]  = 1'b1;
    @(negedge clk);
    pre_en[d]  = 1'b0;
  endtask

  task automatic check_idle(input int d);
    check("rst_cfg_ready", 32'(cfg_ready_s[d]), 32'd0);
    check("rst_head", 32'(head_s[d]), 32'd0);
    check("rst_shift_en", 32'(shen_s[d]), 32'd0);
    check("rst_rb_data", 32'(rb_data_s[d]), 32'd0);
    check("rst_rb_valid", 32'(rbv_s[d]), 32'd0);
    check("rst_busy", 32'(busy_s[d]), 32'd0);
    check("rst_done", 32'(done_s[d]), 32'd0);
  endtask

  task automatic wait_ready(input int d);
    bit ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (cfg_ready_s[d]) ok = 1'b1;
      else @(negedge clk);
    end
    check("wait_cfg_ready", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input int d, input logic [7:0] w);
    cfg_data_s[d]  = w;
    cfg_valid_s[d] = 1'b1;
    @(negedge clk);
    cfg_valid_s[d] = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    int d   = v.d;
    int nw  = (v.d == 0) ? 1 : 3;
    int len = (v.d == 0) ? 8 : 20;
    int s0, d0;
    bit ok;
    preload(d, v.pre);
    for (int i = 0; i < nw; i++) begin
      if (d == 0) exp_q0.push_back(v.exp_rb[i]);
      else exp_q1.push_back(v.exp_rb[i]);
    end
    s0 = shift_cnt[d];
    d0 = done_cnt[d];
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    for (int i = 0; i < nw; i++) begin
      wait_ready(d);
      if (i == 0) begin
        for (int k = 0; k < v.stall; k++) begin
          check("stall_shift_en", 32'(shen_s[d]), 32'd0);
          check("stall_cfg_ready", 32'(cfg_ready_s[d]), 32'd1);
          check("stall_chain", 32'(chain[d]), 32'(v.pre));
          @(negedge clk);
        end
      end
      send_word(d, v.w[i]);
      if (v.noise) begin
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (done_s[d]) begin
        ok = 1'b1;
        if (v.noise) start_s[d] = 1'b1;
      end
      @(negedge clk);
      start_s[d] = 1'b0;
    end
    check("done_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("idle_after_done", 32'(busy_s[d]), 32'd0);
    check("done_count", 32'(done_cnt[d] - d0), 32'd1);
    check("shift_count", 32'(shift_cnt[d] - s0), 32'(len));
    check("chain_final", 32'(chain[d]), 32'(v.exp_chain));
    check("rb_drained", 32'((d == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, d0, r0, n;
    clk = 1'b0;
    n_chk = 0;
    n_fail = 0;
    prog_reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; abort_s[d] = 1'b0; cfg_data_s[d] = 8'h00; cfg_valid_s[d] = 1'b0;
      pre_en[d] = 1'b0; pre_val[d] = 20'h0; shift_cnt[d] = 0; done_cnt[d] = 0;
      rb_cnt[d] = 0; prev_shen[d] = 1'b0;
    end
    vecs[0] = '{0, 20'h000A5, 24'h00003C, 0, 1'b0, 20'h0003C, 24'h0000A5};
    vecs[1] = '{0, 20'h00000, 24'h0000FF, 5, 1'b0, 20'h000FF, 24'h000000};
    vecs[2] = '{0, 20'h0005A, 24'h000081, 0, 1'b1, 20'h00081, 24'h00005A};
    vecs[3] = '{1, 20'hABCDE, 24'hFF2211, 0, 1'b0, 20'hF2211, 24'h0ABCDE};
    vecs[4] = '{1, 20'hFFFFF, 24'h3F55AA, 5, 1'b1, 20'hF55AA, 24'h0FFFFF};

    repeat (3) @(negedge clk);
    prog_reset = 1'b0;
    check_idle(0);
    check_idle(1);

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Abort on the 4th shift cycle: that edge still shifts, then the loader drops to IDLE.
    preload(0, 20'h000A5);
    d0 = done_cnt[0];
    r0 = rb_cnt[0];
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_ready(0);
    send_word(0, 8'h3C);
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (shen_s[0]) n++;
      if (n == 4) abort_s[0] = 1'b1;
      @(negedge clk);
      abort_s[0] = 1'b0;
    end
    check("abort_reached_4", 32'(n), 32'd4);
    check("abort_shift_en", 32'(shen_s[0]), 32'd0);
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
    check("abort_no_rb", 32'(rb_cnt[0] - r0), 32'd0);
    check("abort_chain", 32'(chain[0]), 32'h000CA);

    // abort is ignored in IDLE but honoured in FETCH.
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    check("abort_idle_ignored", 32'(cfg_ready_s[0]), 32'd1);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort_fetch_busy", 32'(busy_s[0]), 32'd0);

    // Reset in the middle of the second word of the 20-bit load.
    preload(1, 20'hABCDE);
    exp_q1.push_back(8'hDE);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    wait_ready(1);
    send_word(1, 8'h11);
    wait_ready(1);
    send_word(1, 8'h22);
    repeat (2) @(negedge clk);
    check("pre_reset_shifting", 32'(shen_s[1]), 32'd1);
    check("pre_reset_rb_data", 32'(rb_data_s[1]), 32'h000000DE);
    prog_reset = 1'b1;
    @(negedge clk);
    prog_reset = 1'b0;
    check_idle(1);
    exp_q1.delete();
    run_load(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration controller that programs one configuration-chain segment, e.g. the 8-bit chain through the four size-2 routing-mux memories of a corner switch block.
- Accepts bitstream words from the host over a valid/ready handshake and serializes them LSB-first onto ccff_head.
- Gates chain shifting with ccff_shift_en, counts exactly CHAIN_LEN shifts, then reports done.
- While shifting, captures the outgoing old configuration from ccff_tail and returns it as readback words.

Parameters:
- CHAIN_LEN, 8: number of configuration flops in the chain; legal range 1..4095.
- WORD_W, 8: host word width in bits; legal range 1..32.
- CNT_W, 12: bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  in  1  programming clock; the only clock.
- prog_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- abort  in  1  stops shifting at the next edge and returns to IDLE without asserting done.
- cfg_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  word accepted on a cycle where cfg_valid && cfg_ready.
- ccff_head  out  1  serial data into the chain.
- ccff_shift_en  out  1  chain flops capture ccff_head on a prog_clk edge only while this is 1 (drives the external clock gate).
- ccff_tail  in  1  serial output of the last chain flop.
- rb_data  out  WORD_W  readback word, LSB = first bit out of the tail.
- rb_valid  out  1  one-cycle pulse; rb_data is valid; no backpressure.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final shift.

Behaviour:
- Clock and reset: one clock, prog_clk. Reset is synchronous and active-high (prog_reset); polarity and synchronicity are fixed.
- Reset values (taking effect at the edge where prog_reset is sampled high): state=IDLE, cfg_ready=0, ccff_head=0, ccff_shift_en=0, rb_data=0, rb_valid=0, busy=0, done=0, all counters=0. This holds mid-shift too; the chain keeps whatever partial contents it has.
- States: IDLE, FETCH, SHIFT, DONE.
- IDLE:
  - start=1 -> FETCH; bit counter cleared.
  - abort is ignored in IDLE.
- FETCH:
  - cfg_ready=1; shift_en=0.
  - On handshake: latch the word into the shift register, set the word-bit index to 0, go to SHIFT.
  - While cfg_valid=0, stay in FETCH indefinitely; the chain does not move.
- SHIFT:
  - ccff_head = sreg[0]; ccff_shift_en=1; cfg_ready=0.
  - Each cycle: sample ccff_tail into rbuf at the word-bit index (this is the value before the edge), shift sreg right, increment bit counter and index.
  - When the counter reaches CHAIN_LEN: emit the final readback word, then go to DONE.
  - When the index reaches WORD_W first: emit the readback word, then go to FETCH.
  - Throughput: 1 shift per cycle inside a word; 1 idle FETCH cycle minimum between words.
- Partial last word: if CHAIN_LEN mod WORD_W = r != 0, only bits [r-1:0] of the last word are shifted. The remaining bits are discarded. rb_data bits above r-1 are 0.
- rb_valid: pulses the cycle after the last shift of each word; rb_data holds until the next pulse.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- abort:
  - Sampled high in FETCH or SHIFT -> IDLE at that edge, shift_en=0 the same edge.
  - No done, no rb_valid for the partial word.
  - abort has priority over handshake and counter completion in the same cycle.
- start while busy: ignored.
- Counter never wraps: completion is checked with equality to CHAIN_LEN before increment.

Decomposition:
- Package ccff_loader_pkg:
  - state enum (IDLE, FETCH, SHIFT, DONE);
  - localparams LAST_BITS = CHAIN_LEN mod WORD_W and N_WORDS = ceil(CHAIN_LEN/WORD_W);
  - helper function for the per-word bit limit.
- Sub-module ccff_word_serializer:
  - holds the WORD_W shift register, the readback buffer and the word-bit index;
  - inputs: load, shift, limit;
  - outputs: head bit, word_end, rb word.
- The FSM and bit counter stay in the top module.

Test Plan:
- Default params, chain model = 8 flops preloaded 0xA5: start, cfg_data=0x3C -> 8 consecutive shift_en cycles with head sequence 0,0,1,1,1,1,0,0; rb_data=0xA5 with rb_valid one cycle after the last shift; done pulse; chain holds 0x3C.
- CHAIN_LEN=20, WORD_W=8: three words 0x11, 0x22, 0xFF -> exactly 20 shifts. Third word contributes only bits 0x F low nibble. Third rb_data has bits [7:4]=0. done once.
- cfg_valid held low for 5 cycles in FETCH -> shift_en stays 0, cfg_ready stays 1, chain unchanged; resumes correctly when valid rises.
- abort asserted on the 4th SHIFT cycle -> shift_en=0 at the next edge, busy=0, no done, no rb_valid; the chain has moved exactly 4 bits.
- prog_reset pulse mid-SHIFT -> all outputs equal reset values after that edge; a fresh start then completes a full load normally.
- start pulsed during SHIFT and in the DONE cycle -> ignored; exactly one done per accepted start.
